// File: rtl/servo_bank.sv
`default_nettype none
// ============================================================================
// Module   : servo_bank
// Purpose  : Multi-channel servo PWM generator. A shared frame counter drives
//            CHANNELS pulse outputs. Targets are written via an addressed
//            port and clamped to [MIN_WIDTH, MAX_WIDTH]. At each frame
//            boundary the live width walks toward the target by at most STEP,
//            so every pulse uses a single width and is never a runt.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            enable       - output enable, latched at frame boundaries
//            wr_en        - write strobe (one write per asserted cycle)
//            wr_ch        - channel index for the write
//            wr_width     - requested pulse width in cycles
//            pwm          - servo pulse outputs, bit i = channel i
//            frame_start  - one-cycle pulse on the first cycle of each frame
//            settled      - bit i high when current width equals target
// Revision : 1.0 - initial release
// ============================================================================
module servo_bank #(
  parameter int CHANNELS    = 2,
  parameter int PERIOD      = 2000000,
  parameter int MIN_WIDTH   = 100000,
  parameter int MAX_WIDTH   = 200000,
  parameter int RESET_WIDTH = 150000,
  parameter int STEP        = 2000,
  parameter int CH_W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [31:0]         wr_width,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_start,
  output logic [CHANNELS-1:0] settled
);

  localparam int          CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(PERIOD - 1);
  localparam logic [31:0] c_min   = 32'(MIN_WIDTH);
  localparam logic [31:0] c_max   = 32'(MAX_WIDTH);
  localparam logic [31:0] c_rst_w = 32'(RESET_WIDTH);
  localparam logic [31:0] c_step  = 32'(STEP);

  logic [CNT_W-1:0]    r_count;
  logic                r_en_q;
  logic                w_boundary;
  logic [31:0]         w_clamped;
  logic [CHANNELS-1:0] w_pwm_next;
  logic [CHANNELS-1:0] w_settled_next;

  assign w_boundary = (r_count == c_last);

  // Clamp is shared by all channels; only the addressed one loads it.
  assign w_clamped = (wr_width < c_min) ? c_min :
                     (wr_width > c_max) ? c_max : wr_width;

  // Frame counter and boundary-sampled enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_en_q  <= 1'b0;
    end else begin
      r_count <= w_boundary ? '0 : r_count + CNT_W'(1);
      if (w_boundary) begin
        r_en_q <= enable;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [31:0] r_cur;
    logic [31:0] r_tgt;
    logic [31:0] w_cur_next;
    logic [31:0] w_tgt_next;

    // Direction is decided first so the magnitude subtraction is always
    // larger-minus-smaller and cannot wrap.
    always_comb begin
      w_cur_next = r_cur;
      w_tgt_next = r_tgt;
      if (w_boundary) begin
        if (r_tgt > r_cur) begin
          if ((c_step == 32'd0) || ((r_tgt - r_cur) <= c_step)) begin
            w_cur_next = r_tgt;
          end else begin
            w_cur_next = r_cur + c_step;
          end
        end else if (r_tgt < r_cur) begin
          if ((c_step == 32'd0) || ((r_cur - r_tgt) <= c_step)) begin
            w_cur_next = r_tgt;
          end else begin
            w_cur_next = r_cur - c_step;
          end
        end
      end
      // Full-width compare, so out-of-range indices match no channel.
      if (wr_en && (wr_ch == CH_W'(gi))) begin
        w_tgt_next = w_clamped;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cur <= c_rst_w;
        r_tgt <= c_rst_w;
      end else begin
        r_cur <= w_cur_next;
        r_tgt <= w_tgt_next;
      end
    end

    assign w_pwm_next[gi]     = r_en_q && (32'(r_count) < r_cur);
    assign w_settled_next[gi] = (w_cur_next == w_tgt_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm         <= '0;
      frame_start <= 1'b0;
      settled     <= '1;
    end else begin
      pwm         <= w_pwm_next;
      frame_start <= (r_count == '0);
      settled     <= w_settled_next;
    end
  end

endmodule
`default_nettype wire
